gate_activation: RTL and testbench
==================================

# gate_activation

Post-processing stage that sits directly downstream of `dot_prod`. When `dot_prod` pulses `dataReady`, this block captures the NROW-wide pre-activation vector, adds a per-row bias with saturation, and applies a shift-only piecewise-linear sigmoid or tanh. It processes one row per cycle through a two-stage pipeline and presents the activated vector with a one-cycle `outValid` pulse for the LSTM gate/state logic.

## Interface
- NROW, 16: rows per vector; must match `dot_prod`.
- QN, 6: integer bits of the signed fixed-point format.
- QM, 11: fractional bits.
- ACT_TYPE, 0: activation select, 0 = sigmoid, 1 = tanh; fixed at elaboration.
- BITWIDTH (derived), QN+QM+1 = 18: element width. VEC_BITWIDTH (derived) = BITWIDTH*NROW.
- clock  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-low. When 0 at a rising edge, all state is cleared.
- dataReady  in  1  one-cycle pulse from `dot_prod`: `inputVec` is valid.
- inputVec  in  VEC_BITWIDTH  pre-activations. Row r occupies [r*BITWIDTH +: BITWIDTH], signed Q6.11.
- biasVec  in  VEC_BITWIDTH  per-row bias, same packing. Sampled together with `inputVec`.
- busy  out  1  high from the capture edge until `outValid` drops.
- outValid  out  1  one-cycle pulse: `outVec` is complete.
- outVec  out  VEC_BITWIDTH  activated vector, same packing, Q6.11.

## Operation
- Reset values: state IDLE, `busy`=0, `outValid`=0, `outVec`=0, row index=0, pipeline valid flags=0.
- State machine:
  - IDLE -> RUN on an edge with `dataReady`=1. At that edge, `inputVec` and `biasVec` are latched, idx=0 and `busy`=1.
  - RUN: on each edge, stage 1 computes s1 = sat(x[idx]+b[idx]) and idx increments. When idx=NROW-1 is issued, go to DRAIN.
  - DRAIN: one edge for stage 2 to write the last row, with `outValid` set at that same edge. Then go to DONE.
  - DONE -> IDLE at the next edge, clearing `outValid` and `busy`.
- Stage 2 writes `outVec[s1_idx]` = act(s1). No other row of `outVec` changes. Rows still hold the previous result until they are overwritten.
- `dataReady` while `busy`=1 is ignored; no queueing.
- Add/saturate: compute the sum at 19 bits, then clamp to [-131072, 131071].
- Sigmoid, with a = |s| computed on 18 bits. Negate 131071 for -131072 so that a ≤ 131071. All constants are in Q6.11.
  - a ≥ 10240 (5.0): y = 2048.
  - 4864 ≤ a < 10240: y = (a>>>5) + 1728.
  - 2048 ≤ a < 4864: y = (a>>>3) + 1280.
  - a < 2048: y = (a>>>2) + 1024.
  - The shift truncates toward zero, since a ≥ 0.
  - If s < 0, the result is 2048 - y. The result always lies in [0, 2048].
- Tanh: t = sat(2s), then result = 2*sigmoid(t) - 2048. The result always lies in [-2048, 2048].
- Reset low mid-run: the block returns to IDLE at that edge, `outVec` is cleared, and no `outValid` is produced.

## Timing
- Capture edge E0 is the edge where `dataReady`=1 is sampled in IDLE.
- Row r enters stage 1 at edge E0+1+r and is written to `outVec` at edge E0+2+r.
- Last row is written at E0+NROW+1. `outValid`=1 in the cycle following that edge, exactly one cycle. `busy` falls at E0+NROW+2.
- Latency from `dataReady` to `outValid` is NROW+1 edges; for NROW=16 that is 17.
- Minimum spacing between accepted `dataReady` pulses is NROW+2 cycles. `dot_prod` spacing (≥ NCOL + reload) must respect this.
- `outVec` is stable from `outValid` until edge E0'+2 of the next run.

## Test plan
- Reset then zero input: reset=0 for 2 cycles, then `dataReady` with all x=0, b=0, ACT_TYPE=0. Expect `outValid` exactly 17 edges later and every row = 1024. Check `outVec`=0 and `busy`=0 during reset.
- Sigmoid regions: rows x = 2048, -2048, 4096, 6000, 12000, -12000 with b=0. Expect 1536, 512, 1792, 1915, 2048, 0.
- Bias and saturation: x=131071, b=100 gives 2048. x=-131072, b=-5 gives 0. x=1000, b=1048 (sum 2048) gives 1536.
- Tanh (ACT_TYPE=1): x = 0, 2048, -2048, 20000 give 0, 1536, -1536, 2048.
- Busy and back-to-back: a second `dataReady` 5 cycles after the first is ignored; exactly one `outValid` occurs. A pulse sent in the cycle after `busy` falls is accepted, and the new result appears 17 edges later.
- Reset mid-run: reset=0 at E0+8. Expect no `outValid`, `outVec`=0 and `busy`=0 on the next cycle. A subsequent `dataReady` completes normally.

Source files
------------

// File: rtl/gate_activation.sv
// Bias-add, saturate and shift-only PWL sigmoid/tanh over an NROW vector captured on a dataReady pulse.
// Latency NROW+1 edges to the outValid pulse; dataReady pulses arriving while busy are dropped.
module gate_activation #(
  parameter  int NROW         = 16,
  parameter  int QN           = 6,
  parameter  int QM           = 11,
  parameter  int ACT_TYPE     = 0,
  localparam int BITWIDTH     = QN + QM + 1,
  localparam int VEC_BITWIDTH = BITWIDTH * NROW
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    dataReady,
  input  logic [VEC_BITWIDTH-1:0] inputVec,
  input  logic [VEC_BITWIDTH-1:0] biasVec,
  output logic                    busy,
  output logic                    outValid,
  output logic [VEC_BITWIDTH-1:0] outVec
);

  localparam int IDXW = $clog2(NROW);

  localparam logic [BITWIDTH-1:0] SAT_MAX = {1'b0, {(BITWIDTH-1){1'b1}}};
  localparam logic [BITWIDTH-1:0] SAT_MIN = {1'b1, {(BITWIDTH-1){1'b0}}};
  localparam logic [BITWIDTH-1:0] ONE     = BITWIDTH'(2048);
  localparam logic [BITWIDTH-1:0] BRK_HI  = BITWIDTH'(10240);
  localparam logic [BITWIDTH-1:0] BRK_MID = BITWIDTH'(4864);
  localparam logic [BITWIDTH-1:0] BRK_LO  = BITWIDTH'(2048);
  localparam logic [BITWIDTH-1:0] OFS_HI  = BITWIDTH'(1728);
  localparam logic [BITWIDTH-1:0] OFS_MID = BITWIDTH'(1280);
  localparam logic [BITWIDTH-1:0] OFS_LO  = BITWIDTH'(1024);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                  state;
  state_t                  stateNext;
  logic [VEC_BITWIDTH-1:0] xReg;
  logic [VEC_BITWIDTH-1:0] bReg;
  logic [IDXW-1:0]         idx;
  logic [BITWIDTH-1:0]     s1;
  logic [IDXW-1:0]         s1Idx;
  logic                    s1Valid;
  logic [BITWIDTH-1:0]     actOut;

  // One guard bit catches overflow; clamp toward the sign of the true sum.
  function automatic logic [BITWIDTH-1:0] satAdd(input logic [BITWIDTH-1:0] a,
                                                 input logic [BITWIDTH-1:0] b);
    logic [BITWIDTH:0] sum;
    sum = {a[BITWIDTH-1], a} + {b[BITWIDTH-1], b};
    if (sum[BITWIDTH] != sum[BITWIDTH-1])
      return sum[BITWIDTH] ? SAT_MIN : SAT_MAX;
    return sum[BITWIDTH-1:0];
  endfunction

  function automatic logic [BITWIDTH-1:0] sigmoid(input logic [BITWIDTH-1:0] s);
    logic [BITWIDTH-1:0] a;
    logic [BITWIDTH-1:0] y;
    if (s == SAT_MIN)
      a = SAT_MAX;
    else if (s[BITWIDTH-1])
      a = -s;
    else
      a = s;
    if (a >= BRK_HI)
      y = ONE;
    else if (a >= BRK_MID)
      y = (a >> 5) + OFS_HI;
    else if (a >= BRK_LO)
      y = (a >> 3) + OFS_MID;
    else
      y = (a >> 2) + OFS_LO;
    return s[BITWIDTH-1] ? (ONE - y) : y;
  endfunction

  // tanh(s) = 2*sigmoid(2s) - 1, with 2s saturated like any other sum.
  function automatic logic [BITWIDTH-1:0] tanhAct(input logic [BITWIDTH-1:0] s);
    logic [BITWIDTH-1:0] sig;
    sig = sigmoid(satAdd(s, s));
    return {sig[BITWIDTH-2:0], 1'b0} - ONE;
  endfunction

  always_ff @(posedge clock) begin
    if (!reset)
      state <= IDLE;
    else
      state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (dataReady) stateNext = RUN;
      RUN:     if (idx == IDXW'(NROW - 1)) stateNext = DRAIN;
      DRAIN:   stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  assign busy     = (state != IDLE);
  assign outValid = (state == DONE);
  assign actOut   = (ACT_TYPE == 1) ? tanhAct(s1) : sigmoid(s1);

  always_ff @(posedge clock) begin
    if (!reset) begin
      xReg    <= '0;
      bReg    <= '0;
      idx     <= '0;
      s1      <= '0;
      s1Idx   <= '0;
      s1Valid <= 1'b0;
      outVec  <= '0;
    end else begin
      s1Valid <= 1'b0;
      if (state == IDLE && dataReady) begin
        xReg <= inputVec;
        bReg <= biasVec;
        idx  <= '0;
      end
      if (state == RUN) begin
        s1      <= satAdd(xReg[idx*BITWIDTH +: BITWIDTH], bReg[idx*BITWIDTH +: BITWIDTH]);
        s1Idx   <= idx;
        s1Valid <= 1'b1;
        idx     <= idx + IDXW'(1);
      end
      // Only the row leaving stage 1 is written; other rows keep the previous result.
      if (s1Valid)
        outVec[s1Idx*BITWIDTH +: BITWIDTH] <= actOut;
    end
  end

endmodule

// File: tb/tb_gate_activation.sv
// Directed bench for gate_activation: a sigmoid and a tanh instance share one stimulus stream.
module tb_gate_activation;

  localparam int NROW = 16;
  localparam int BW   = 18;
  localparam int VW   = BW * NROW;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          dataReady = 1'b0;
  logic [VW-1:0] inputVec = '0;
  logic [VW-1:0] biasVec = '0;
  logic          busyS, outValidS, busyT, outValidT;
  logic [VW-1:0] outVecS, outVecT;

  int compared = 0;
  int mismatched = 0;

  always #5 clock = ~clock;

  gate_activation #(.NROW(NROW), .QN(6), .QM(11), .ACT_TYPE(0)) dutS (
    .clock(clock), .reset(reset), .dataReady(dataReady), .inputVec(inputVec),
    .biasVec(biasVec), .busy(busyS), .outValid(outValidS), .outVec(outVecS));

  gate_activation #(.NROW(NROW), .QN(6), .QM(11), .ACT_TYPE(1)) dutT (
    .clock(clock), .reset(reset), .dataReady(dataReady), .inputVec(inputVec),
    .biasVec(biasVec), .busy(busyT), .outValid(outValidT), .outVec(outVecT));

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [VW-1:0] pack(input int v[NROW]);
    logic [VW-1:0] r;
    int            e;
    r = '0;
    for (int i = 0; i < NROW; i++) begin
      e = v[i];
      r[i*BW +: BW] = e[BW-1:0];
    end
    return r;
  endfunction

  function automatic int row(input logic [VW-1:0] v, input int r);
    logic signed [BW-1:0] e;
    e = v[r*BW +: BW];
    return int'(e);
  endfunction

  task automatic launch(input logic [VW-1:0] x, input logic [VW-1:0] b);
    inputVec  = x;
    biasVec   = b;
    dataReady = 1'b1;
    tick();
    dataReady = 1'b0;
  endtask

  task automatic waitValid(output int n);
    n = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (outValidS) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    compared++;
    if (outVecS !== '0 || outVecT !== '0) begin
      mismatched++;
      $display("FAIL reset_outVec: got %h / %h, want 0", outVecS, outVecT);
    end
    compared++;
    if (busyS !== 1'b0 || busyT !== 1'b0 || outValidS !== 1'b0 || outValidT !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_flags: busy %b%b outValid %b%b, want all 0", busyS, busyT, outValidS, outValidT);
    end
    reset = 1'b1;
  endtask

  task automatic test_zero();
    int xs[NROW];
    int n;
    xs = '{default: 0};
    launch(pack(xs), pack(xs));
    compared++;
    if (busyS !== 1'b1) begin
      mismatched++;
      $display("FAIL zero_busy_rise: got %b, want 1", busyS);
    end
    waitValid(n);
    compared++;
    if (n !== 17) begin
      mismatched++;
      $display("FAIL zero_latency: got %0d edges, want 17", n);
    end
    for (int r = 0; r < NROW; r++) begin
      compared++;
      if (row(outVecS, r) !== 1024 || row(outVecT, r) !== 0) begin
        mismatched++;
        $display("FAIL zero_row%0d: sig %0d tanh %0d, want 1024 0", r, row(outVecS, r), row(outVecT, r));
      end
    end
    tick();
    compared++;
    if (outValidS !== 1'b0 || busyS !== 1'b0) begin
      mismatched++;
      $display("FAIL zero_pulse_end: outValid %b busy %b, want 0 0", outValidS, busyS);
    end
  endtask

  task automatic test_sigmoid_regions();
    int xs[NROW];
    int zs[NROW];
    int expv[6];
    int n;
    xs = '{default: 0};
    zs = '{default: 0};
    xs[0] = 2048; xs[1] = -2048; xs[2] = 4096; xs[3] = 6000; xs[4] = 12000; xs[5] = -12000;
    expv = '{1536, 512, 1792, 1915, 2048, 0};
    launch(pack(xs), pack(zs));
    waitValid(n);
    compared++;
    if (n !== 17) begin
      mismatched++;
      $display("FAIL sig_latency: got %0d edges, want 17", n);
    end
    for (int r = 0; r < 6; r++) begin
      compared++;
      if (row(outVecS, r) !== expv[r]) begin
        mismatched++;
        $display("FAIL sig_row%0d: got %0d, want %0d", r, row(outVecS, r), expv[r]);
      end
    end
    compared++;
    if (row(outVecS, 15) !== 1024) begin
      mismatched++;
      $display("FAIL sig_row15: got %0d, want 1024", row(outVecS, 15));
    end
    tick();
  endtask

  task automatic test_bias_sat();
    int xs[NROW];
    int bs[NROW];
    int expv[3];
    int n;
    xs = '{default: 0};
    bs = '{default: 0};
    xs[0] = 131071;  bs[0] = 100;
    xs[1] = -131072; bs[1] = -5;
    xs[2] = 1000;    bs[2] = 1048;
    expv = '{2048, 0, 1536};
    launch(pack(xs), pack(bs));
    waitValid(n);
    for (int r = 0; r < 3; r++) begin
      compared++;
      if (row(outVecS, r) !== expv[r]) begin
        mismatched++;
        $display("FAIL bias_row%0d: got %0d, want %0d", r, row(outVecS, r), expv[r]);
      end
    end
    tick();
  endtask

  task automatic test_tanh();
    int xs[NROW];
    int zs[NROW];
    int expv[4];
    int n;
    xs = '{default: 0};
    zs = '{default: 0};
    xs[0] = 0; xs[1] = 2048; xs[2] = -2048; xs[3] = 20000;
    expv = '{0, 1536, -1536, 2048};
    launch(pack(xs), pack(zs));
    waitValid(n);
    for (int r = 0; r < 4; r++) begin
      compared++;
      if (row(outVecT, r) !== expv[r]) begin
        mismatched++;
        $display("FAIL tanh_row%0d: got %0d, want %0d", r, row(outVecT, r), expv[r]);
      end
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int xs[NROW];
    int zs[NROW];
    int pulses;
    int firstAt;
    int fallAt;
    int n;
    xs = '{default: 0};
    zs = '{default: 0};
    pulses = 0; firstAt = -1; fallAt = -1;
    xs[0] = 2048;
    launch(pack(xs), pack(zs));
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (outValidS) begin
        pulses++;
        if (firstAt < 0) firstAt = k;
      end
      if (k == 4) begin
        xs[0] = -2048;
        inputVec  = pack(xs);
        dataReady = 1'b1;
      end
      if (k == 5) dataReady = 1'b0;
      if (k > 17 && !busyS) begin
        fallAt = k;
        break;
      end
    end
    compared++;
    if (pulses !== 1 || firstAt !== 17) begin
      mismatched++;
      $display("FAIL b2b_pulses: got %0d pulses first at %0d, want 1 at 17", pulses, firstAt);
    end
    compared++;
    if (fallAt !== 18) begin
      mismatched++;
      $display("FAIL b2b_busy_fall: got edge %0d, want 18", fallAt);
    end
    compared++;
    if (row(outVecS, 0) !== 1536) begin
      mismatched++;
      $display("FAIL b2b_ignored_data: got %0d, want 1536", row(outVecS, 0));
    end
    launch(pack(xs), pack(zs));
    waitValid(n);
    compared++;
    if (n !== 17 || row(outVecS, 0) !== 512) begin
      mismatched++;
      $display("FAIL b2b_second_run: latency %0d row0 %0d, want 17 512", n, row(outVecS, 0));
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int xs[NROW];
    int zs[NROW];
    int pulses;
    int n;
    xs = '{default: 0};
    zs = '{default: 0};
    pulses = 0;
    xs[0] = 2048;
    launch(pack(xs), pack(zs));
    for (int k = 1; k <= 7; k++) tick();
    reset = 1'b0;
    tick();
    compared++;
    if (outVecS !== '0 || busyS !== 1'b0 || outValidS !== 1'b0) begin
      mismatched++;
      $display("FAIL midreset_clear: outVec %h busy %b outValid %b, want 0", outVecS, busyS, outValidS);
    end
    reset = 1'b1;
    for (int k = 0; k < 25; k++) begin
      tick();
      if (outValidS) pulses++;
    end
    compared++;
    if (pulses !== 0) begin
      mismatched++;
      $display("FAIL midreset_no_valid: got %0d pulses, want 0", pulses);
    end
    xs[0] = 4096;
    launch(pack(xs), pack(zs));
    waitValid(n);
    compared++;
    if (n !== 17 || row(outVecS, 0) !== 1792) begin
      mismatched++;
      $display("FAIL midreset_rerun: latency %0d row0 %0d, want 17 1792", n, row(outVecS, 0));
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_zero();
    test_sigmoid_regions();
    test_bias_sat();
    test_tanh();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
